// File: rtl/updown_counter_led.sv
// Parametrised up/down counter with prescaler, step size, synchronous load,
// wrap or saturate limit handling, a one-cycle wrap pulse and min/max flags.
// The top LED_W bits of the count drive an LED bank one cycle later.
module updown_counter_led #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned LED_W    = 4,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned STEP     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [LED_W-1:0] Led,
  output logic             wrap,
  output logic             at_max,
  output logic             at_min
);

  // The prescaler needs at least one bit even when PRESCALE is 1.
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]  PRE_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0]  PRE_ONE   = PW'(1);
  localparam logic [WIDTH:0] STEP_EXT  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_MIN = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_r;
  logic [LED_W-1:0] led_r;
  logic             wrap_r;
  logic [PW-1:0]    pre_r;

  logic             step_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] next_count_s;
  logic             next_wrap_s;

  // Next count and wrap flag for a step; the extra MSB of the sum/difference
  // flags overflow (carry) or underflow (borrow) past a limit.
  always_comb begin
    step_s       = en && (pre_r == PRE_MAX);
    sum_s        = {1'b0, count_r} + STEP_EXT;
    diff_s       = {1'b0, count_r} - STEP_EXT;
    next_count_s = count_r;
    next_wrap_s  = 1'b0;
    if (dir) begin
      if (sum_s[WIDTH]) begin
        if (sat_mode) begin
          next_count_s = CNT_MAX;
          next_wrap_s  = 1'b0;
        end else begin
          next_count_s = sum_s[WIDTH-1:0];
          next_wrap_s  = 1'b1;
        end
      end else begin
        next_count_s = sum_s[WIDTH-1:0];
        next_wrap_s  = 1'b0;
      end
    end else begin
      if (diff_s[WIDTH]) begin
        if (sat_mode) begin
          next_count_s = CNT_MIN;
          next_wrap_s  = 1'b0;
        end else begin
          next_count_s = diff_s[WIDTH-1:0];
          next_wrap_s  = 1'b1;
        end
      end else begin
        next_count_s = diff_s[WIDTH-1:0];
        next_wrap_s  = 1'b0;
      end
    end
  end

  // Counter, prescaler and wrap pulse: reset > load > step > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= CNT_MIN;
      pre_r   <= PRE_ZERO;
      wrap_r  <= 1'b0;
    end else if (load) begin
      count_r <= load_val;
      pre_r   <= PRE_ZERO;
      wrap_r  <= 1'b0;
    end else if (step_s) begin
      count_r <= next_count_s;
      pre_r   <= PRE_ZERO;
      wrap_r  <= next_wrap_s;
    end else begin
      wrap_r  <= 1'b0;
      if (en) begin
        pre_r <= pre_r + PRE_ONE;
      end else begin
        pre_r <= pre_r;
      end
    end
  end

  // LED bank mirrors the top count bits one cycle behind the counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_r <= {LED_W{1'b0}};
    end else begin
      led_r <= count_r[WIDTH-1 -: LED_W];
    end
  end

  assign count  = count_r;
  assign Led    = led_r;
  assign wrap   = wrap_r;
  // Limit flags decode the count register directly, no extra latency.
  assign at_max = (count_r == CNT_MAX);
  assign at_min = (count_r == CNT_MIN);

endmodule

// File: tb/tb_updown_counter_led.sv
// Bench for updown_counter_led: two instances (STEP=1 and STEP=5) share the
// same stimulus; a behavioural model pushes expected results to a queue
// before each clock and they are popped and compared one time unit after.
module tb_updown_counter_led;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, sat_mode, load;
  logic [7:0] load_val;
  logic [7:0] count_a, count_b;
  logic [3:0] led_a, led_b;
  logic       wrap_a, wrap_b, at_max_a, at_max_b, at_min_a, at_min_b;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int cnt[2];
    int wrp[2];
    int led[2];
  } exp_t;

  exp_t exp_q[$];

  int m_count[2];
  int m_pre[2];
  int m_wrap[2];
  int m_led[2];

  always #5 clk = ~clk;

  updown_counter_led #(.WIDTH(8), .LED_W(4), .PRESCALE(3), .STEP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(count_a), .Led(led_a),
    .wrap(wrap_a), .at_max(at_max_a), .at_min(at_min_a)
  );

  updown_counter_led #(.WIDTH(8), .LED_W(4), .PRESCALE(3), .STEP(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .count(count_b), .Led(led_b),
    .wrap(wrap_b), .at_max(at_max_b), .at_min(at_min_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural next state for one instance, using plain integer arithmetic.
  task automatic model(input int idx, input int stepv);
    int t;
    if (!rst_n) begin
      m_count[idx] = 0; m_pre[idx] = 0; m_wrap[idx] = 0; m_led[idx] = 0;
    end else begin
      m_led[idx]  = m_count[idx] / 16;
      m_wrap[idx] = 0;
      if (load) begin
        m_count[idx] = int'(load_val);
        m_pre[idx]   = 0;
      end else if (en) begin
        if (m_pre[idx] == 2) begin
          m_pre[idx] = 0;
          t = dir ? m_count[idx] + stepv : m_count[idx] - stepv;
          if (t > 255) begin
            if (sat_mode) m_count[idx] = 255;
            else begin m_count[idx] = t - 256; m_wrap[idx] = 1; end
          end else if (t < 0) begin
            if (sat_mode) m_count[idx] = 0;
            else begin m_count[idx] = t + 256; m_wrap[idx] = 1; end
          end else begin
            m_count[idx] = t;
          end
        end else begin
          m_pre[idx] = m_pre[idx] + 1;
        end
      end
    end
  endtask

  // One clock: predict, push, clock, pop and compare every output.
  task automatic tick();
    exp_t e;
    model(0, 1);
    model(1, 5);
    for (int i = 0; i < 2; i++) begin
      e.cnt[i] = m_count[i]; e.wrp[i] = m_wrap[i]; e.led[i] = m_led[i];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("count_a", 32'(count_a), 32'(e.cnt[0]));
      check("count_b", 32'(count_b), 32'(e.cnt[1]));
      check("wrap_a",  32'(wrap_a),  32'(e.wrp[0]));
      check("wrap_b",  32'(wrap_b),  32'(e.wrp[1]));
      check("led_a",   32'(led_a),   32'(e.led[0]));
      check("led_b",   32'(led_b),   32'(e.led[1]));
      check("at_max_a", 32'(at_max_a), 32'(e.cnt[0] == 255));
      check("at_max_b", 32'(at_max_b), 32'(e.cnt[1] == 255));
      check("at_min_a", 32'(at_min_a), 32'(e.cnt[0] == 0));
      check("at_min_b", 32'(at_min_b), 32'(e.cnt[1] == 0));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int wrap_seen;
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_led[i] = 0;
    end
    rst_n = 1'b0; en = 1'b0; dir = 1'b0; sat_mode = 1'b0;
    load = 1'b0; load_val = 8'h00;

    // 1: reset, then count up every third clock; LED follows one clock later.
    ticks(2);
    check("rst_count", 32'(count_a), 32'h0);
    check("rst_led",   32'(led_a),   32'h0);
    check("rst_wrap",  32'(wrap_a),  32'h0);
    rst_n = 1'b1; en = 1'b1; dir = 1'b1;
    ticks(2);
    check("pre_hold_count", 32'(count_a), 32'h0);
    tick();
    check("first_step_a", 32'(count_a), 32'h1);
    check("first_step_b", 32'(count_b), 32'h5);
    ticks(45);
    check("count_0x10", 32'(count_a), 32'h10);
    check("led_lag",    32'(led_a),   32'h0);
    tick();
    check("led_0x1",    32'(led_a),   32'h1);

    // 2: wrap past the top in wrap mode.
    load = 1'b1; load_val = 8'hFE; sat_mode = 1'b0;
    tick();
    load = 1'b0;
    check("load_fe", 32'(count_a), 32'hFE);
    ticks(3);
    check("up_ff",     32'(count_a),  32'hFF);
    check("at_max_ff", 32'(at_max_a), 32'h1);
    ticks(3);
    check("wrap_00",   32'(count_a),  32'h00);
    check("wrap_pulse",32'(wrap_a),   32'h1);
    check("at_min_00", 32'(at_min_a), 32'h1);
    tick();
    check("wrap_one_cycle", 32'(wrap_a), 32'h0);

    // 3: saturate at zero counting down; wrap never asserts.
    load = 1'b1; load_val = 8'h01; dir = 1'b0; sat_mode = 1'b1;
    tick();
    load = 1'b0;
    wrap_seen = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (wrap_a || wrap_b) wrap_seen = 1;
    end
    check("sat_min_hold", 32'(count_a), 32'h0);
    check("sat_no_wrap",  32'(wrap_seen), 32'h0);

    // 4: STEP=5 underflow wraps, then saturates at the top.
    load = 1'b1; load_val = 8'h03; sat_mode = 1'b0;
    tick();
    load = 1'b0;
    ticks(3);
    check("step5_fe",   32'(count_b), 32'hFE);
    check("step5_wrap", 32'(wrap_b),  32'h1);
    load = 1'b1; load_val = 8'hFD; sat_mode = 1'b1; dir = 1'b1;
    tick();
    load = 1'b0;
    ticks(3);
    check("step5_sat_ff",   32'(count_b), 32'hFF);
    check("step5_sat_nowr", 32'(wrap_b),  32'h0);
    ticks(3);
    check("step5_sat_hold", 32'(count_b), 32'hFF);

    // 5: load beats a due step and restarts the prescaler; en=0 freezes all.
    sat_mode = 1'b0; load_val = 8'h40;
    ticks(2);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("load_wins", 32'(count_a), 32'h40);
    ticks(2);
    check("load_pre_reset", 32'(count_a), 32'h40);
    tick();
    check("step_after_load", 32'(count_a), 32'h41);
    tick();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("frozen_count", 32'(count_a), 32'h41);
      check("frozen_led",   32'(led_a),   32'h4);
    end
    en = 1'b1;
    tick();
    check("pre_frozen", 32'(count_a), 32'h41);
    tick();
    check("resume_step", 32'(count_a), 32'h42);

    // 6: reset while a wrapping step is pending discards it.
    load = 1'b1; load_val = 8'hFF;
    tick();
    load = 1'b0;
    ticks(2);
    rst_n = 1'b0;
    tick();
    check("mid_rst_count", 32'(count_a), 32'h0);
    check("mid_rst_led",   32'(led_a),   32'h0);
    check("mid_rst_wrap",  32'(wrap_a),  32'h0);
    rst_n = 1'b1;
    ticks(2);
    check("restart_hold", 32'(count_a), 32'h0);
    tick();
    check("restart_step", 32'(count_a), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
